delay_sequencer: RTL and testbench
==================================

// Module: delay_sequencer
// PURPOSE
//  Drives the 2 kHz period counter (act/clear inputs) and consumes its two-second flag.
//  Sits between the BlackJack game FSM and the counter.
//  On a request it times N consecutive counter periods (2^COUNT_WIDTH cycles each,
//  about 2.048 s at the default width), then returns a one-cycle done pulse.
//  Also provides busy, abort and remaining-period status for display pacing.
// PARAMETERS
//  COUNT_WIDTH   12  width of the attached counter; one period = 2^COUNT_WIDTH clk_2K cycles
//  PERIOD_WIDTH   4  width of the period-count request and status (max 2^PERIOD_WIDTH-1 periods)
// PORTS
//  clk_2K        in   1             2 kHz clock
//  i_Reset       in   1             reset, synchronous, active-low
//  i_Req         in   1             start request, level, sampled only in IDLE
//  i_Periods     in   PERIOD_WIDTH  number of periods to wait, latched when the request is accepted
//  i_Abort       in   1             cancel the wait in progress, no done pulse
//  i_TwoSec      in   1             counter flag: period complete (combinational from counter)
//  o_ActCounter  out  1             counter enable
//  o_RstCounter  out  1             counter clear (counter gives it priority over enable)
//  o_Busy        out  1             high from acceptance until return to IDLE (excludes DONE)
//  o_Done        out  1             one-cycle pulse when all periods have elapsed
//  o_Remaining   out  PERIOD_WIDTH  periods still to elapse (r_Target - r_Elapsed); 0 in IDLE
// BEHAVIOUR
//  - Reset (i_Reset=0 at edge): state=IDLE, r_Target=0, r_Elapsed=0.
//    Outputs during and after reset: act=0, rst=1, busy=0, done=0, remaining=0.
//  - Moore FSM, all outputs decoded from registered state/regs.
//  - Counter value on reset release is irrelevant: IDLE holds rst=1, so it clears at the first edge.
//  - IDLE  : act=0, rst=1.
//      i_Req=1 and i_Periods=0 -> DONE (zero-length wait).
//      i_Req=1 and i_Periods>0 -> latch r_Target=i_Periods, r_Elapsed=0 -> RUN.
//  - RUN   : act=1, rst=0, busy=1. Counter runs from 0 and saturates at max.
//      i_Abort=1 -> IDLE (wins over i_TwoSec in the same cycle).
//      i_TwoSec=1 and r_Elapsed+1==r_Target -> r_Elapsed++ -> DONE.
//      i_TwoSec=1 otherwise -> r_Elapsed++ -> WRAP.
//  - WRAP  : act=1, rst=1 for exactly one cycle, counter clears to 0, busy=1.
//      i_Abort=1 -> IDLE; else -> RUN.
//  - DONE  : o_Done=1, act=0, rst=1, busy=0; one cycle, then -> IDLE unconditionally.
//      i_Req and i_Abort are ignored in DONE.
//  - Timing: edge 0 = the edge that accepts i_Req.
//      RUN lasts 2^COUNT_WIDTH cycles per period; one WRAP cycle sits between periods.
//      o_Done goes high after edge N*2^COUNT_WIDTH + N-1 and lasts one cycle.
//  - i_Req while busy is not queued. A level-held i_Req restarts the wait from the IDLE
//    cycle after DONE.
//  - i_TwoSec is ignored outside RUN.
//  - r_Elapsed never exceeds r_Target; o_Remaining never underflows.
//  - Illegal/unused state encodings -> IDLE at the next edge.
//  - i_Reset=0 in any state -> IDLE at that edge, no o_Done.
//    Counter clear is asserted while reset is held.
// TESTING (bench pairs DUT with a behavioural counter, COUNT_WIDTH=3, PERIOD_WIDTH=4)
//  1. i_Periods=2, i_Req pulse at edge 0 -> RUN cycles 1-8, WRAP at 9, RUN 10-17.
//     Then o_Done=1 for exactly one cycle after edge 17; o_Busy=0 afterwards.
//  2. i_Periods=0, i_Req pulse -> o_Done after edge 0, one cycle.
//     o_ActCounter stays 0 and o_Busy stays 0 throughout.
//  3. i_Periods=3, assert i_Abort at cycle 12 -> IDLE at next edge, no o_Done ever.
//     o_RstCounter=1, o_Remaining=0.
//  4. i_Periods=1, i_Reset=0 at cycle 5 for 3 cycles -> outputs at reset values, no o_Done.
//     A new request after release gives o_Done after edge 8.
//  5. i_Periods=2, i_Abort and i_TwoSec high in the same cycle -> abort wins: IDLE, r_Elapsed unchanged.
//     i_Req toggled while busy -> ignored.
//  6. o_Remaining check with i_Periods=3 -> reads 3,2,1 across the periods.
//     Returns to 0 in IDLE; o_RstCounter high exactly in IDLE, WRAP and DONE.

Source files
------------

// File: rtl/delay_sequencer.sv
// -----------------------------------------------------------------------------
// delay_sequencer
//
// Paces the BlackJack game FSM in whole periods of the external 2 kHz period
// counter. A request asks for N periods. The sequencer enables the counter,
// waits for its two-second flag, clears it for one cycle between periods, and
// after the last period raises a one-cycle done pulse. An abort cancels the wait
// without a done pulse. Busy and remaining-period status are provided for
// display pacing.
//
// Parameters
//   COUNT_WIDTH   width of the attached counter; one period = 2**COUNT_WIDTH cycles
//   PERIOD_WIDTH  width of the period request and remaining-period status
//
// Ports
//   clk_2K        in   1             2 kHz clock
//   i_Reset       in   1             synchronous reset, active-low
//   i_Req         in   1             start request (level), sampled only when idle
//   i_Periods     in   PERIOD_WIDTH  number of periods to wait, latched on acceptance
//   i_Abort       in   1             cancel the wait in progress, no done pulse
//   i_TwoSec      in   1             counter flag: current period complete
//   o_ActCounter  out  1             counter enable
//   o_RstCounter  out  1             counter clear (the counter gives it priority)
//   o_Busy        out  1             waiting (running or between periods)
//   o_Done        out  1             one-cycle pulse after the last period
//   o_Remaining   out  PERIOD_WIDTH  periods still to elapse; 0 when idle
// -----------------------------------------------------------------------------
module delay_sequencer #(
   parameter int COUNT_WIDTH  = 12,
   parameter int PERIOD_WIDTH = 4
) (
   input  logic                    clk_2K,
   input  logic                    i_Reset,
   input  logic                    i_Req,
   input  logic [PERIOD_WIDTH-1:0] i_Periods,
   input  logic                    i_Abort,
   input  logic                    i_TwoSec,
   output logic                    o_ActCounter,
   output logic                    o_RstCounter,
   output logic                    o_Busy,
   output logic                    o_Done,
   output logic [PERIOD_WIDTH-1:0] o_Remaining
);

   // The period length lives entirely in the attached counter; the width is
   // only checked here so a misconfigured instance fails at elaboration.
   if (COUNT_WIDTH < 1 || PERIOD_WIDTH < 1) begin : g_bad_width
      $error("delay_sequencer: COUNT_WIDTH and PERIOD_WIDTH must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WRAP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                  state, state_nxt;
   logic [PERIOD_WIDTH-1:0] target, target_nxt;
   logic [PERIOD_WIDTH-1:0] elapsed, elapsed_nxt;

   always_ff @(posedge clk_2K) begin
      if (!i_Reset) begin
         state   <= S_IDLE;
         target  <= '0;
         elapsed <= '0;
      end else begin
         state   <= state_nxt;
         target  <= target_nxt;
         elapsed <= elapsed_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      target_nxt  = target;
      elapsed_nxt = elapsed;
      case (state)
         S_IDLE: begin
            if (i_Req) begin
               // Latched even for a zero-length wait so remaining reads 0 in DONE.
               target_nxt  = i_Periods;
               elapsed_nxt = '0;
               state_nxt   = (i_Periods == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Abort outranks a period completing in the same cycle.
            if (i_Abort) begin
               state_nxt = S_IDLE;
            end else if (i_TwoSec) begin
               elapsed_nxt = elapsed + 1'b1;
               // >= rather than == so a corrupted count still terminates.
               state_nxt   = (elapsed_nxt >= target) ? S_DONE : S_WRAP;
            end
         end
         S_WRAP: begin
            state_nxt = i_Abort ? S_IDLE : S_RUN;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs decode the registered state. They are also forced to their idle
   // values while reset is held, so the counter is cleared and no done pulse
   // can escape during the reset cycles themselves.
   logic in_run, in_wrap, in_done;

   assign in_run  = i_Reset && (state == S_RUN);
   assign in_wrap = i_Reset && (state == S_WRAP);
   assign in_done = i_Reset && (state == S_DONE);

   assign o_ActCounter = in_run | in_wrap;
   assign o_RstCounter = ~in_run;
   assign o_Busy       = in_run | in_wrap;
   assign o_Done       = in_done;
   assign o_Remaining  = (in_run | in_wrap | in_done) ? (target - elapsed) : '0;

endmodule

// File: tb/tb_delay_sequencer.sv
// -----------------------------------------------------------------------------
// tb_delay_sequencer
//
// Directed bench for delay_sequencer with a small behavioural period counter
// (COUNT_WIDTH=3, so a period is 8 cycles). Edge 0 is the edge that accepts a
// request; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_delay_sequencer;

   localparam int CW = 3;
   localparam int PW = 4;

   logic          clk_2K = 1'b0;
   logic          i_Reset;
   logic          i_Req;
   logic [PW-1:0] i_Periods;
   logic          i_Abort;
   logic          i_TwoSec;
   logic          o_ActCounter;
   logic          o_RstCounter;
   logic          o_Busy;
   logic          o_Done;
   logic [PW-1:0] o_Remaining;

   int checks = 0;
   int errors = 0;

   always #5 clk_2K = ~clk_2K;

   delay_sequencer #(
      .COUNT_WIDTH (CW),
      .PERIOD_WIDTH(PW)
   ) dut (
      .clk_2K      (clk_2K),
      .i_Reset     (i_Reset),
      .i_Req       (i_Req),
      .i_Periods   (i_Periods),
      .i_Abort     (i_Abort),
      .i_TwoSec    (i_TwoSec),
      .o_ActCounter(o_ActCounter),
      .o_RstCounter(o_RstCounter),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_Remaining (o_Remaining)
   );

   // Behavioural period counter: clear has priority, counts when enabled,
   // saturates at its maximum, flag is combinational on the maximum.
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_2K) begin
      if (o_RstCounter)
         cnt <= '0;
      else if (o_ActCounter && (cnt != {CW{1'b1}}))
         cnt <= cnt + 1'b1;
   end

   assign i_TwoSec = (cnt == {CW{1'b1}});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic a, input logic r, input logic b,
                       input logic d, input logic [PW-1:0] rem);
      chk({tag, "/act"},  32'(o_ActCounter), 32'(a));
      chk({tag, "/rst"},  32'(o_RstCounter), 32'(r));
      chk({tag, "/busy"}, 32'(o_Busy),       32'(b));
      chk({tag, "/done"}, 32'(o_Done),       32'(d));
      chk({tag, "/rem"},  32'(o_Remaining),  32'(rem));
   endtask

   task automatic step();
      @(posedge clk_2K);
      #1;
   endtask

   task automatic run(input int n, input string tag, input logic a, input logic r,
                      input logic b, input logic d, input logic [PW-1:0] rem);
      for (int k = 0; k < n; k++) begin
         step();
         outs(tag, a, r, b, d, rem);
      end
   endtask

   initial begin
      i_Reset   = 1'b0;
      i_Req     = 1'b0;
      i_Periods = '0;
      i_Abort   = 1'b0;

      // Reset state
      run(2, "reset", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      i_Reset = 1'b1;
      run(2, "idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 1: two periods, done after edge 17
      i_Periods = 4'd2;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t1 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
      run(7, "t1 run1", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2); // edges 1..7
      run(1, "t1 wrap", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1); // edge 8
      run(8, "t1 run2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1); // edges 9..16
      run(1, "t1 done", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0); // edge 17
      run(2, "t1 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 2: zero-length wait
      i_Periods = 4'd0;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t2 done", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
      run(2, "t2 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 3: three periods, abort during the second period
      i_Periods = 4'd3;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t3 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
      run(7, "t3 run1", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3); // edges 1..7
      run(1, "t3 wrap", 1'b1, 1'b1, 1'b1, 1'b0, 4'd2); // edge 8
      run(3, "t3 run2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2); // edges 9..11
      i_Abort = 1'b1;
      run(1, "t3 abort", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); // edge 12
      i_Abort = 1'b0;
      run(20, "t3 after", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 4: reset in the middle of a one-period wait, then a fresh request
      i_Periods = 4'd1;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t4 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      run(4, "t4 run", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);  // edges 1..4
      i_Reset = 1'b0;
      #1;
      outs("t4 held", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      run(3, "t4 reset", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); // edges 5..7
      i_Reset = 1'b1;
      run(4, "t4 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      i_Req = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t4b run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      run(7, "t4b run", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1); // edges 1..7
      run(1, "t4b done", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0); // edge 8
      run(1, "t4b idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 5: request while busy is ignored; abort beats the period flag
      i_Periods = 4'd2;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t5 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
      run(2, "t5 run", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);  // edges 1..2
      i_Req = 1'b1;
      run(2, "t5 reqbusy", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2); // edges 3..4
      i_Req = 1'b0;
      run(3, "t5 run", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);  // edges 5..7
      chk("t5 flag", 32'(i_TwoSec), 32'd1);
      i_Abort = 1'b1;
      run(1, "t5 abort", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); // edge 8
      chk("t5 elapsed", 32'(dut.elapsed), 32'd0);
      i_Abort = 1'b0;
      run(3, "t5 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // 6: remaining counts down 3,2,1; clear high in IDLE, WRAP, DONE only
      i_Periods = 4'd3;
      i_Req     = 1'b1;
      step();                                         // edge 0
      i_Req = 1'b0;
      outs("t6 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
      run(7, "t6 p1", 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);   // edges 1..7
      run(1, "t6 wrap1", 1'b1, 1'b1, 1'b1, 1'b0, 4'd2); // edge 8
      run(8, "t6 p2", 1'b1, 1'b0, 1'b1, 1'b0, 4'd2);   // edges 9..16
      run(1, "t6 wrap2", 1'b1, 1'b1, 1'b1, 1'b0, 4'd1); // edge 17
      run(8, "t6 p3", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);   // edges 18..25
      run(1, "t6 done", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0); // edge 26
      run(2, "t6 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      // Level-held request restarts from the IDLE cycle after DONE
      i_Periods = 4'd1;
      i_Req     = 1'b1;
      step();                                         // edge 0
      outs("t7 run0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
      run(7, "t7 run", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);  // edges 1..7
      run(1, "t7 done", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0); // edge 8
      run(1, "t7 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); // edge 9
      run(1, "t7 again", 1'b1, 1'b0, 1'b1, 1'b0, 4'd1); // edge 10
      i_Req   = 1'b0;
      i_Abort = 1'b1;
      run(1, "t7 abort", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); // edge 11
      i_Abort = 1'b0;
      run(2, "t7 idle", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
